// File: rtl/usb_rx_packet_parser.sv
// Packet stage behind the USB transceiver RX path: strips SYNC, validates the PID,
// checks CRC5/CRC16, streams data payload without its CRC and reports per-packet status.
module usb_rx_packet_parser #(
    parameter int MAX_PAYLOAD  = 64,
    parameter bit SYNC_PRESENT = 1'b1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_eop,
    output logic [3:0] pid,
    output logic       pid_valid,
    output logic [6:0] tok_addr,
    output logic [3:0] tok_endp,
    output logic       tok_valid,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       pkt_done,
    output logic       pkt_ok,
    output logic       err_sync,
    output logic       err_pid,
    output logic       err_crc,
    output logic       err_len,
    output logic [6:0] byte_count
);

    // Stream semantics: rx_valid, rx_eop and every *_valid / pkt_done output are
    // single-cycle strobes with no ready; a strobe is consumed in the cycle it is high.

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_TOKEN,
        S_DATA,
        S_HSHAKE,
        S_DISCARD
    } state_t;

    localparam logic [4:0]  CRC5_RES  = 5'b01100;
    localparam logic [15:0] CRC16_RES = 16'h800D;
    localparam logic [6:0]  MAX_CNT   = 7'(MAX_PAYLOAD);

    state_t      state, n_state;
    logic [4:0]  crc5, n_crc5;
    logic [15:0] crc16, n_crc16;
    logic [7:0]  tok_b1, n_tok_b1;
    logic [7:0]  hold0, n_hold0, hold1, n_hold1;
    logic [1:0]  tok_cnt, n_tok_cnt, hold_cnt, n_hold_cnt;
    logic        acc_sync, n_acc_sync, acc_pid, n_acc_pid, acc_len, n_acc_len;

    logic [3:0]  n_pid;
    logic        n_pid_valid, n_tok_valid, n_data_out_valid;
    logic [6:0]  n_tok_addr, n_byte_count;
    logic [3:0]  n_tok_endp;
    logic [7:0]  n_data_out;
    logic        n_pkt_done, n_pkt_ok, n_err_sync, n_err_pid, n_err_crc, n_err_len;
    logic        take_pid, pid_good, accept_pid, eop_len, eop_crc;

    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic [7:0] d);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        n_state          = state;
        n_crc5           = crc5;
        n_crc16          = crc16;
        n_tok_b1         = tok_b1;
        n_hold0          = hold0;
        n_hold1          = hold1;
        n_tok_cnt        = tok_cnt;
        n_hold_cnt       = hold_cnt;
        n_acc_sync       = acc_sync;
        n_acc_pid        = acc_pid;
        n_acc_len        = acc_len;
        n_pid            = pid;
        n_pid_valid      = 1'b0;
        n_tok_addr       = tok_addr;
        n_tok_endp       = tok_endp;
        n_tok_valid      = 1'b0;
        n_data_out       = data_out;
        n_data_out_valid = 1'b0;
        n_byte_count     = byte_count;
        n_pkt_done       = 1'b0;
        n_pkt_ok         = pkt_ok;
        n_err_sync       = err_sync;
        n_err_pid        = err_pid;
        n_err_crc        = err_crc;
        n_err_len        = err_len;
        take_pid         = 1'b0;
        accept_pid       = 1'b0;
        eop_len          = 1'b0;
        eop_crc          = 1'b0;
        pid_good         = (rx_data[7:4] == ~rx_data[3:0]);

        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    // First byte of a new packet: previous status is dropped here.
                    n_acc_sync   = 1'b0;
                    n_acc_pid    = 1'b0;
                    n_acc_len    = 1'b0;
                    n_err_sync   = 1'b0;
                    n_err_pid    = 1'b0;
                    n_err_crc    = 1'b0;
                    n_err_len    = 1'b0;
                    n_pkt_ok     = 1'b0;
                    n_byte_count = '0;
                    n_tok_cnt    = '0;
                    n_hold_cnt   = '0;
                    n_crc5       = '1;
                    n_crc16      = '1;
                    if (SYNC_PRESENT) begin
                        if (rx_data != 8'h80) begin
                            n_acc_sync = 1'b1;
                            n_state    = S_DISCARD;
                        end else begin
                            n_state = S_PID;
                        end
                    end else begin
                        take_pid = 1'b1;
                    end
                end
                S_PID: take_pid = 1'b1;
                S_TOKEN: begin
                    n_crc5 = crc5_step(crc5, rx_data);
                    if (tok_cnt == 2'd0) begin
                        n_tok_b1 = rx_data;
                    end else if (tok_cnt == 2'd1 && n_crc5 == CRC5_RES) begin
                        n_tok_valid = 1'b1;
                        n_tok_addr  = tok_b1[6:0];
                        n_tok_endp  = {rx_data[2:0], tok_b1[7]};
                    end
                    if (tok_cnt != 2'd3) n_tok_cnt = tok_cnt + 2'd1;
                end
                S_DATA: begin
                    n_crc16 = crc16_step(crc16, rx_data);
                    if (hold_cnt == 2'd0) begin
                        n_hold0    = rx_data;
                        n_hold_cnt = 2'd1;
                    end else if (hold_cnt == 2'd1) begin
                        n_hold1    = rx_data;
                        n_hold_cnt = 2'd2;
                    end else if (byte_count == MAX_CNT) begin
                        n_acc_len = 1'b1;
                        n_state   = S_DISCARD;
                    end else begin
                        // The two newest bytes may be the CRC, so only the oldest leaves.
                        n_data_out       = hold0;
                        n_data_out_valid = 1'b1;
                        n_hold0          = hold1;
                        n_hold1          = rx_data;
                        n_byte_count     = byte_count + 7'd1;
                    end
                end
                S_HSHAKE: n_acc_len = 1'b1;
                default: ;
            endcase

            if (take_pid) begin
                if (!pid_good) begin
                    n_acc_pid = 1'b1;
                    n_state   = S_DISCARD;
                end else begin
                    case (rx_data[1:0])
                        2'b01: begin n_state = S_TOKEN;  accept_pid = 1'b1; end
                        2'b11: begin n_state = S_DATA;   accept_pid = 1'b1; end
                        2'b10: begin n_state = S_HSHAKE; accept_pid = 1'b1; end
                        default: begin
                            if (rx_data[3:0] == 4'hC) begin
                                n_state    = S_HSHAKE;
                                accept_pid = 1'b1;
                            end else begin
                                n_acc_pid = 1'b1;
                                n_state   = S_DISCARD;
                            end
                        end
                    endcase
                end
                if (accept_pid) begin
                    n_pid       = rx_data[3:0];
                    n_pid_valid = 1'b1;
                end
            end
        end

        // End of packet is judged on the post-byte view so a byte sharing the EOP cycle counts.
        if (rx_eop && n_state != S_IDLE) begin
            eop_len = (n_state == S_PID)
                   || (n_state == S_TOKEN && n_tok_cnt != 2'd2)
                   || (n_state == S_DATA && n_hold_cnt != 2'd2);
            eop_crc = (n_state == S_TOKEN && n_tok_cnt == 2'd2 && n_crc5 != CRC5_RES)
                   || (n_state == S_DATA && n_hold_cnt == 2'd2 && n_crc16 != CRC16_RES);
            n_err_sync = n_acc_sync;
            n_err_pid  = n_acc_pid;
            n_err_crc  = eop_crc;
            n_err_len  = n_acc_len | eop_len;
            n_pkt_ok   = !(n_acc_sync | n_acc_pid | eop_crc | n_acc_len | eop_len);
            n_pkt_done = 1'b1;
            n_state    = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            crc5           <= '1;
            crc16          <= '1;
            tok_b1         <= '0;
            hold0          <= '0;
            hold1          <= '0;
            tok_cnt        <= '0;
            hold_cnt       <= '0;
            acc_sync       <= 1'b0;
            acc_pid        <= 1'b0;
            acc_len        <= 1'b0;
            pid            <= '0;
            pid_valid      <= 1'b0;
            tok_addr       <= '0;
            tok_endp       <= '0;
            tok_valid      <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            byte_count     <= '0;
            pkt_done       <= 1'b0;
            pkt_ok         <= 1'b0;
            err_sync       <= 1'b0;
            err_pid        <= 1'b0;
            err_crc        <= 1'b0;
            err_len        <= 1'b0;
        end else begin
            state          <= n_state;
            crc5           <= n_crc5;
            crc16          <= n_crc16;
            tok_b1         <= n_tok_b1;
            hold0          <= n_hold0;
            hold1          <= n_hold1;
            tok_cnt        <= n_tok_cnt;
            hold_cnt       <= n_hold_cnt;
            acc_sync       <= n_acc_sync;
            acc_pid        <= n_acc_pid;
            acc_len        <= n_acc_len;
            pid            <= n_pid;
            pid_valid      <= n_pid_valid;
            tok_addr       <= n_tok_addr;
            tok_endp       <= n_tok_endp;
            tok_valid      <= n_tok_valid;
            data_out       <= n_data_out;
            data_out_valid <= n_data_out_valid;
            byte_count     <= n_byte_count;
            pkt_done       <= n_pkt_done;
            pkt_ok         <= n_pkt_ok;
            err_sync       <= n_err_sync;
            err_pid        <= n_err_pid;
            err_crc        <= n_err_crc;
            err_len        <= n_err_len;
        end
    end

endmodule

// File: doc/usb_rx_packet_parser.md
Name: usb_rx_packet_parser

Overview:
- Packet-level stage directly downstream of the USB transceiver RX path. Consumes its deserialised byte stream (rx_data / rx_valid / rx_eop).
- Strips SYNC, validates the PID, and classifies the packet as token, data or handshake.
- Checks CRC5 on tokens and CRC16 on data packets. Streams data payload with the CRC bytes removed, then reports a per-packet status to the protocol engine.

Parameters:
MAX_PAYLOAD, 64, max data payload bytes; more than this raises err_len
SYNC_PRESENT, 1, 1 = first byte of each packet is SYNC (expected 8'h80) and is checked then dropped; 0 = first byte is PID

Ports:
clk  input  1  system clock
RST  input  1  asynchronous active-high reset
rx_data  input  8  received byte, LSB = first bit on wire
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_eop  input  1  one-cycle strobe, end of packet
pid  output  4  PID[3:0] of current packet, held until next packet's PID
pid_valid  output  1  one-cycle pulse, PID accepted (check field good)
tok_addr  output  7  token address (SOF: frame[6:0])
tok_endp  output  4  token endpoint (SOF: frame[10:7])
tok_valid  output  1  one-cycle pulse, token fields captured, CRC5 good
data_out  output  8  payload byte
data_out_valid  output  1  one-cycle pulse per payload byte
pkt_done  output  1  one-cycle pulse, packet finished (status valid this cycle)
pkt_ok  output  1  with pkt_done: no error
err_sync  output  1  with pkt_done: SYNC byte mismatch
err_pid  output  1  with pkt_done: rx_data[7:4] != ~rx_data[3:0], or reserved PID
err_crc  output  1  with pkt_done: CRC residual mismatch
err_len  output  1  with pkt_done: wrong byte count for packet class
byte_count  output  7  payload bytes emitted in current/last packet

Behaviour:
- Reset (async, RST=1): state IDLE.
  - pid=0, tok_addr=0, tok_endp=0, byte_count=0; all pulses and error flags 0; CRC registers all-ones; holding regs cleared.
  - Reset mid-packet abandons the packet silently: no pkt_done is issued.
- FSM states and transitions:
  - IDLE: first rx_valid goes to PID, or to SYNC check if SYNC_PRESENT.
  - SYNC: byte != 8'h80 sets err_sync and goes to DISCARD; otherwise next byte goes to PID.
  - PID: check field bad goes to DISCARD with err_pid. Otherwise by pid[1:0]:
    - 01 token -> TOKEN
    - 11 data -> DATA
    - 10 handshake -> HSHAKE
    - 00 special: PRE (4'hC) -> HSHAKE; all others -> DISCARD with err_pid
- TOKEN:
  - Exactly 2 bytes. CRC5 (poly x^5+x^2+1, init 5'b11111) runs over all 16 bits LSB-first.
  - Residual must equal 5'b01100, else err_crc.
  - tok_addr = byte1[6:0]; tok_endp = {byte2[2:0], byte1[7]}.
  - tok_valid pulses the cycle after byte 2 if the CRC is good.
- DATA:
  - CRC16 (poly 0x8005, init 16'hFFFF) runs over all bytes after the PID, LSB-first. Residual must equal 16'h800D.
  - Two-byte holding FIFO: each new byte beyond the second pushes out the oldest on data_out, 1 cycle after its rx_valid. byte_count increments per emitted byte.
  - At EOP the two held bytes are the CRC and are never emitted.
  - Fewer than 2 bytes after PID raises err_len.
  - byte_count reaching MAX_PAYLOAD with another byte arriving: err_len is set, emission stops, state goes to DISCARD.
- HSHAKE: any byte after the PID raises err_len.
- DISCARD: ignores bytes until rx_eop.
- EOP handling:
  - rx_eop in any non-IDLE state: pkt_done pulses on the next cycle, then IDLE.
  - pkt_ok = no error flag set.
  - TOKEN ending with fewer than 2 bytes raises err_len.
  - Error flags clear when the next packet starts.
- Boundary cases:
  - rx_valid and rx_eop in the same cycle: the byte is processed first, then EOP.
  - rx_eop while in IDLE: ignored, no pkt_done.
  - rx_valid after EOP with no gap: starts a new packet.
- Latency:
  - pid_valid: 1 cycle after the PID byte strobe.
  - pkt_done: 1 cycle after rx_eop.
- No backpressure: the consumer must accept every data_out_valid pulse.

Test Plan:
- SETUP token: 80 2D 00 10 + eop -> pid_valid with pid=4'hD; tok_valid with addr=0, endp=0; pkt_done with pkt_ok=1.
- DATA0 GET_DESCRIPTOR: 80 C3 80 06 00 01 00 00 40 00 DD 94 + eop -> data_out = 80,06,00,01,00,00,40,00 (8 pulses); byte_count=8; pkt_ok=1.
- Data CRC corruption: same packet with last byte 95 -> 8 bytes still emitted; pkt_done with err_crc=1, pkt_ok=0. Zero-length DATA1 (80 4B 00 00) -> no data_out pulses, pkt_ok=1.
- ACK handshake: 80 D2 + eop -> pid=4'h2, pkt_ok=1. Sending 80 D2 55 + eop instead -> err_len=1.
- Bad PID (80 D3) and bad SYNC (81 2D 00 10): err_pid=1 and err_sync=1 respectively; no pid_valid or tok_valid; pkt_done follows eop.
- Overflow and reset: 65-byte DATA0 payload with MAX_PAYLOAD=64 -> 64 bytes out then err_len. Separately, assert RST after 3 payload bytes -> all outputs 0, no pkt_done; the next packet parses normally.
